// File: rtl/pipe_stage1.sv
// ============================================================================
// Module   : pipe_stage1
// Brief    : Instruction fetch stage; merges two-byte instructions into an
//            opcode word plus an aligned immediate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage1 #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [7:0]      NOP      = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic [7:0]        PipeOut,
    output logic [7:0]        Imm,
    output logic              ImmValid,
    output logic [ADDR_W-1:0] PC
);

    typedef enum logic [0:0] {
        FETCH_OP  = 1'b0,
        FETCH_IMM = 1'b1
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [7:0]        r_held;
    logic [7:0]        r_pipe_out;
    logic [7:0]        r_imm;
    logic              r_imm_valid;
    logic              w_is_imm;

    // adi 04-07, mvi 08-0F, sui 30-33 carry a trailing immediate byte
    assign w_is_imm = (mem_data[7:2] == 6'd1)  ||
                      (mem_data[7:3] == 5'd1)  ||
                      (mem_data[7:2] == 6'd12);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FETCH_OP;
            r_pc        <= RESET_PC;
            r_held      <= 8'h00;
            r_pipe_out  <= NOP;
            r_imm       <= 8'h00;
            r_imm_valid <= 1'b0;
        end else if (jump) begin
            r_state     <= FETCH_OP;
            r_pc        <= jump_addr;
            r_pipe_out  <= NOP;
            r_imm_valid <= 1'b0;
        end else if (!stall) begin
            r_pc <= r_pc + 1'b1;
            case (r_state)
                FETCH_OP: begin
                    r_imm_valid <= 1'b0;
                    if (w_is_imm) begin
                        r_held     <= mem_data;
                        r_pipe_out <= NOP;
                        r_state    <= FETCH_IMM;
                    end else begin
                        r_pipe_out <= mem_data;
                    end
                end
                FETCH_IMM: begin
                    r_imm       <= mem_data;
                    r_pipe_out  <= r_held;
                    r_imm_valid <= 1'b1;
                    r_state     <= FETCH_OP;
                end
                default: r_state <= FETCH_OP;
            endcase
        end
    end

    assign mem_addr = r_pc;
    assign PC       = r_pc;
    assign PipeOut  = r_pipe_out;
    assign Imm      = r_imm;
    assign ImmValid = r_imm_valid;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage1.sv
// ============================================================================
// Module   : tb_pipe_stage1
// Brief    : Directed self-checking bench for the fetch stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage1;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       jump;
    logic [7:0] jump_addr;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] PipeOut;
    logic [7:0] Imm;
    logic       ImmValid;
    logic [7:0] PC;

    logic [7:0] mem [0:255];
    int checks = 0;
    int errors = 0;

    assign mem_data = mem[mem_addr];

    always #5 clk = ~clk;

    pipe_stage1 #(
        .ADDR_W   (8),
        .RESET_PC (8'h00),
        .NOP      (8'h00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jump      (jump),
        .jump_addr (jump_addr),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .PipeOut   (PipeOut),
        .Imm       (Imm),
        .ImmValid  (ImmValid),
        .PC        (PC)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks PipeOut/ImmValid/PC, and Imm too when chk_imm is set
    task automatic expect_out(input string tag, input logic [7:0] e_op, input logic e_iv,
                              input logic [7:0] e_pc, input logic chk_imm,
                              input logic [7:0] e_imm);
        check({tag, ".PipeOut"}, PipeOut, e_op);
        check({tag, ".ImmValid"}, {7'd0, ImmValid}, {7'd0, e_iv});
        check({tag, ".PC"}, PC, e_pc);
        if (chk_imm) check({tag, ".Imm"}, Imm, e_imm);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1; stall = 1'b0; jump = 1'b0; jump_addr = 8'h00;

        // reset, then three single-byte opcodes
        mem[0] = 8'h40; mem[1] = 8'h41; mem[2] = 8'hA0;
        step(); expect_out("rst1", 8'h00, 1'b0, 8'h00, 1'b1, 8'h00);
        step(); expect_out("rst2", 8'h00, 1'b0, 8'h00, 1'b1, 8'h00);
        rst = 1'b0;
        step(); expect_out("single0", 8'h40, 1'b0, 8'h01, 1'b0, 8'h00);
        step(); expect_out("single1", 8'h41, 1'b0, 8'h02, 1'b0, 8'h00);
        step(); expect_out("single2", 8'hA0, 1'b0, 8'h03, 1'b0, 8'h00);
        stall = 1'b1;
        step(); expect_out("stall_op", 8'hA0, 1'b0, 8'h03, 1'b0, 8'h00);
        stall = 1'b0;

        // mvi 5A followed by a single-byte opcode
        rst = 1'b1;
        mem[0] = 8'h09; mem[1] = 8'h5A; mem[2] = 8'h40;
        step(); expect_out("rst3", 8'h00, 1'b0, 8'h00, 1'b1, 8'h00);
        rst = 1'b0;
        step(); expect_out("mvi_bubble", 8'h00, 1'b0, 8'h01, 1'b0, 8'h00);
        step(); expect_out("mvi_word", 8'h09, 1'b1, 8'h02, 1'b1, 8'h5A);
        step(); expect_out("after_mvi", 8'h40, 1'b0, 8'h03, 1'b1, 8'h5A);

        // sui with a 3-cycle stall while waiting for its immediate
        mem[8'h10] = 8'h31; mem[8'h11] = 8'h77;
        jump = 1'b1; jump_addr = 8'h10;
        step(); expect_out("jmp10", 8'h00, 1'b0, 8'h10, 1'b0, 8'h00);
        jump = 1'b0;
        step(); expect_out("sui_bubble", 8'h00, 1'b0, 8'h11, 1'b0, 8'h00);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); expect_out("stall_imm", 8'h00, 1'b0, 8'h11, 1'b1, 8'h5A);
        end
        stall = 1'b0;
        step(); expect_out("sui_word", 8'h31, 1'b1, 8'h12, 1'b1, 8'h77);

        // jump with stall mid two-byte fetch abandons the opcode
        mem[8'h12] = 8'h08; mem[8'h13] = 8'h11; mem[8'h20] = 8'hA5;
        step(); expect_out("mvi2_bubble", 8'h00, 1'b0, 8'h13, 1'b0, 8'h00);
        jump = 1'b1; jump_addr = 8'h20; stall = 1'b1;
        step(); expect_out("jmp_flush", 8'h00, 1'b0, 8'h20, 1'b1, 8'h77);
        jump = 1'b0; stall = 1'b0;
        step(); expect_out("after_flush", 8'hA5, 1'b0, 8'h21, 1'b1, 8'h77);

        // adi at FF takes its immediate from address 00
        mem[8'hFF] = 8'h05; mem[8'h00] = 8'h7E;
        jump = 1'b1; jump_addr = 8'hFF;
        step(); expect_out("jmpFF", 8'h00, 1'b0, 8'hFF, 1'b0, 8'h00);
        jump = 1'b0;
        step(); expect_out("wrap_bubble", 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        step(); expect_out("wrap_word", 8'h05, 1'b1, 8'h01, 1'b1, 8'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
